fifo_push_sched: RTL and testbench

Round-robin push scheduler sharing the synchronous write port of one FIFO_16K_BLK half between two requesters. It sits between two producer blocks and the FIFO's PUSH/DIN/Fifo_Push_Flush inputs. It issues at most one push per clock and stops granting when the FIFO push flags report full. It also sequences a timed push-side flush on request.

---
 rtl/fifo_push_sched.sv | 146 ++++++++++++++
 tb/tb_fifo_push_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_sched.sv
// fifo_push_sched
//   Round-robin push scheduler that shares the synchronous write port of one
//   FIFO half between two requesters, and sequences a timed push-side flush.
//
//   Optional statistics counters are built when FIFO_PUSH_SCHED_STATS_EN is
//   defined; otherwise Push_Cnt0/Push_Cnt1/Stall_Cnt are tied to zero.
//
//   Handshake: a requester raises Req with stable Din and holds both until it
//   sees Ack high during a cycle. Ack is a combinational one-cycle accept; at
//   the following edge the requester presents its next word or drops Req.
//   A Req still high after an acked cycle is a new request.
//
// Ports
//   Clk, Rst                 clock, asynchronous active-high reset
//   Req0/Req1, Din0/Din1     requester push requests and data
//   Ack0/Ack1                combinational accept pulses
//   Flush_Req, Flush_Busy    flush request (sampled in IDLE) / busy status
//   PUSH_FLAG, Almost_Full   FIFO push-side status (4'h0 = full)
//   PUSH, DIN                registered FIFO push strobe and data
//   Fifo_Push_Flush          registered FIFO push-side flush
//   Push_Cnt0/1, Stall_Cnt   statistics counters
//   dbg_state                current FSM state (0 IDLE, 1 DRAIN, 2 FLUSH)
module fifo_push_sched #(
  parameter int DW        = 16,
  parameter int FLUSH_CYC = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req0,
  input  logic          Req1,
  input  logic [DW-1:0] Din0,
  input  logic [DW-1:0] Din1,
  output logic          Ack0,
  output logic          Ack1,
  input  logic          Flush_Req,
  output logic          Flush_Busy,
  input  logic [3:0]    PUSH_FLAG,
  input  logic          Almost_Full,
  output logic          PUSH,
  output logic [DW-1:0] DIN,
  output logic          Fifo_Push_Flush,
  output logic [15:0]   Push_Cnt0,
  output logic [15:0]   Push_Cnt1,
  output logic [15:0]   Stall_Cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       last_grant;   // 1 = requester 1 was granted last
  logic       grant0, grant1;
  logic       block;

  // The flags lag one push behind, so a push in flight while almost full
  // already consumes the last free slot.
  assign block = (PUSH_FLAG == 4'h0) | (Almost_Full & PUSH);

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    grant0        = 1'b0;
    grant1        = 1'b0;
    case (state)
      IDLE: begin
        if (Flush_Req) begin
          state_nxt = DRAIN;
        end else if (!block) begin
          if (Req0 && Req1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
          end else begin
            grant0 = Req0;
            grant1 = Req1;
          end
        end
      end
      DRAIN: begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = 4'(FLUSH_CYC - 1);
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Ack0       = grant0;
  assign Ack1       = grant1;
  assign Flush_Busy = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      flush_cnt       <= 4'd0;
      last_grant      <= 1'b1;
      PUSH            <= 1'b0;
      DIN             <= '0;
      Fifo_Push_Flush <= 1'b0;
    end else begin
      state           <= state_nxt;
      flush_cnt       <= flush_cnt_nxt;
      // Registered from next state so the flush strobe aligns with FLUSH.
      Fifo_Push_Flush <= (state_nxt == FLUSH);
      PUSH            <= grant0 | grant1;
      if (grant0) begin
        DIN        <= Din0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        DIN        <= Din1;
        last_grant <= 1'b1;
      end
    end
  end

`ifdef FIFO_PUSH_SCHED_STATS_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Push_Cnt0 <= 16'd0;
      Push_Cnt1 <= 16'd0;
      Stall_Cnt <= 16'd0;
    end else begin
      if (grant0) Push_Cnt0 <= Push_Cnt0 + 16'd1;
      if (grant1) Push_Cnt1 <= Push_Cnt1 + 16'd1;
      if ((state == IDLE) && (Req0 | Req1) && block && (Stall_Cnt != 16'hFFFF))
        Stall_Cnt <= Stall_Cnt + 16'd1;
    end
  end
`else
  assign Push_Cnt0 = 16'd0;
  assign Push_Cnt1 = 16'd0;
  assign Stall_Cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_push_sched.sv
// tb_fifo_push_sched
//   Directed bench for fifo_push_sched. Stimulus cycles push the expected
//   accept id and pushed word into queues; a negedge monitor pops and
//   compares whenever the DUT acks or pushes.
module tb_fifo_push_sched;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0] Din0 = 16'h0, Din1 = 16'h0;
  logic        Ack0, Ack1;
  logic        Flush_Req = 1'b0;
  logic        Flush_Busy;
  logic [3:0]  PUSH_FLAG = 4'h1;
  logic        Almost_Full = 1'b0;
  logic        PUSH;
  logic [15:0] DIN;
  logic        Fifo_Push_Flush;
  logic [15:0] Push_Cnt0, Push_Cnt1, Stall_Cnt;
  logic [1:0]  dbg_state;

  fifo_push_sched #(.DW(16), .FLUSH_CYC(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1), .Din0(Din0), .Din1(Din1),
    .Ack0(Ack0), .Ack1(Ack1),
    .Flush_Req(Flush_Req), .Flush_Busy(Flush_Busy),
    .PUSH_FLAG(PUSH_FLAG), .Almost_Full(Almost_Full),
    .PUSH(PUSH), .DIN(DIN), .Fifo_Push_Flush(Fifo_Push_Flush),
    .Push_Cnt0(Push_Cnt0), .Push_Cnt1(Push_Cnt1), .Stall_Cnt(Stall_Cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic        exp_ack_q[$];   // 0 = Ack0, 1 = Ack1
  logic [15:0] exp_q[$];       // expected DIN per PUSH

  logic        last_push, last_busy, last_flush;
  logic [15:0] last_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Ack0 | Ack1) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", {Ack1, Ack0}, 32'd0);
        else check("ack_id", {31'd0, Ack1}, {31'd0, exp_ack_q.pop_front()});
      end
      if (PUSH) begin
        if (exp_q.size() == 0) check("push_unexpected", 32'd1, 32'd0);
        else check("push_din", DIN, exp_q.pop_front());
      end
    end
  end

  // One cycle of directed input. Called at posedge+1; returns at next posedge+1.
  // ea: 2'b01 expects Ack0, 2'b10 expects Ack1, 2'b00 expects no ack.
  task automatic drive(input logic r0, input logic [15:0] d0,
                       input logic r1, input logic [15:0] d1,
                       input logic fr, input logic [3:0] pf, input logic af,
                       input logic [1:0] ea);
    Req0 = r0; Din0 = d0; Req1 = r1; Din1 = d1;
    Flush_Req = fr; PUSH_FLAG = pf; Almost_Full = af;
    if (ea == 2'b01) begin exp_ack_q.push_back(1'b0); exp_q.push_back(d0); end
    if (ea == 2'b10) begin exp_ack_q.push_back(1'b1); exp_q.push_back(d1); end
    @(negedge Clk);
    check("ack_vec", {Ack1, Ack0}, ea);
    last_push  = PUSH;
    last_din   = DIN;
    last_busy  = Flush_Busy;
    last_flush = Fifo_Push_Flush;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 16'h0, 0, 4'h1, 0, 2'b00);
  endtask

  task automatic check_stats(input string tag, input logic [15:0] c0,
                             input logic [15:0] c1, input logic [15:0] st);
`ifdef FIFO_PUSH_SCHED_STATS_EN
    check({tag, "_cnt0"},  Push_Cnt0, c0);
    check({tag, "_cnt1"},  Push_Cnt1, c1);
    check({tag, "_stall"}, Stall_Cnt, st);
`else
    check({tag, "_cnt0"},  Push_Cnt0, 32'd0 & c0);
    check({tag, "_cnt1"},  Push_Cnt1, 32'd0 & c1);
    check({tag, "_stall"}, Stall_Cnt, 32'd0 & st);
`endif
  endtask

  int n_push, n_busy, n_flush;

  initial begin
    // reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_push",  PUSH, 0);
    check("rst_din",   DIN, 0);
    check("rst_flush", Fifo_Push_Flush, 0);
    check("rst_busy",  Flush_Busy, 0);
    check("rst_acks",  {Ack1, Ack0}, 0);
    check("rst_state", dbg_state, 0);
    check_stats("rst", 16'd0, 16'd0, 16'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // single requester: ack in cycle 0, PUSH/DIN in cycle 1
    drive(1, 16'hA5A5, 0, 16'h0, 0, 4'h1, 0, 2'b01);
    idle();
    check("lat_push", last_push, 1);
    check("lat_din",  last_din, 16'hA5A5);

    // requester 1 alone, leaves pointer at 1
    drive(0, 16'h0, 1, 16'h1111, 0, 4'h1, 0, 2'b10);
    idle();

    // tie for 6 cycles: alternating 0,1,0,1,0,1, back-to-back pushes
    n_push = 0;
    drive(1, 16'h0A00, 1, 16'h0B00, 0, 4'h1, 0, 2'b01);
    drive(1, 16'h0A01, 1, 16'h0B00, 0, 4'h1, 0, 2'b10); n_push += last_push;
    drive(1, 16'h0A01, 1, 16'h0B01, 0, 4'h1, 0, 2'b01); n_push += last_push;
    drive(1, 16'h0A02, 1, 16'h0B01, 0, 4'h1, 0, 2'b10); n_push += last_push;
    drive(1, 16'h0A02, 1, 16'h0B02, 0, 4'h1, 0, 2'b01); n_push += last_push;
    drive(0, 16'h0,    1, 16'h0B02, 0, 4'h1, 0, 2'b10); n_push += last_push;
    idle();                                                n_push += last_push;
    check("tie_push_run", n_push, 6);

    // almost-full with push in flight blocks Req1
    drive(0, 16'h0, 1, 16'h2222, 0, 4'h1, 0, 2'b10);
    drive(0, 16'h0, 1, 16'h3333, 0, 4'h1, 1, 2'b00);
    check_stats("af", 16'd4, 16'd5, 16'd1);
    drive(0, 16'h0, 1, 16'h3333, 0, 4'h1, 0, 2'b10);
    // full flag for 3 cycles
    drive(1, 16'h4444, 0, 16'h0, 0, 4'h0, 0, 2'b00);
    drive(1, 16'h4444, 0, 16'h0, 0, 4'h0, 0, 2'b00);
    drive(1, 16'h4444, 0, 16'h0, 0, 4'h0, 0, 2'b00);
    check_stats("full", 16'd4, 16'd6, 16'd4);
    drive(1, 16'h4444, 0, 16'h0, 0, 4'h1, 0, 2'b01);
    idle();

    // flush wins over a same-cycle request
    n_busy = 0; n_flush = 0;
    drive(1, 16'h5555, 0, 16'h0, 1, 4'h1, 0, 2'b00); n_busy += last_busy; n_flush += last_flush;
    drive(1, 16'h5555, 0, 16'h0, 0, 4'h1, 0, 2'b00); n_busy += last_busy; n_flush += last_flush;
    check("drain_state", dbg_state, 2);
    check("flush_rise_late", last_flush, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h5555, 0, 16'h0, 0, 4'h1, 0, 2'b00);
      n_busy += last_busy; n_flush += last_flush;
    end
    drive(1, 16'h5555, 0, 16'h0, 0, 4'h1, 0, 2'b01); n_busy += last_busy; n_flush += last_flush;
    check("flush_busy_cycles", n_busy, 5);
    check("flush_high_cycles", n_flush, 4);
    idle();
    check_stats("pre_rst", 16'd6, 16'd6, 16'd4);

    // reset during the third FLUSH cycle
    drive(0, 16'h0, 0, 16'h0, 1, 4'h1, 0, 2'b00);
    idle();
    idle();
    idle();
    Flush_Req = 1'b0;
    check("flush3_high", Fifo_Push_Flush, 1);
    #2 Rst = 1'b1;
    #1;
    check("arst_flush", Fifo_Push_Flush, 0);
    check("arst_busy",  Flush_Busy, 0);
    check("arst_push",  PUSH, 0);
    check("arst_state", dbg_state, 0);
    check_stats("arst", 16'd0, 16'd0, 16'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(1, 16'h6000, 1, 16'h7000, 0, 4'h1, 0, 2'b01);
    drive(0, 16'h0,    1, 16'h7000, 0, 4'h1, 0, 2'b10);
    idle();
    idle();
    check_stats("end", 16'd1, 16'd1, 16'd0);

    check("ack_q_drained",  exp_ack_q.size(), 0);
    check("push_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
